// File: rtl/ppg_pkg.sv
// ppg_pkg: shared definitions for the PPG column reducer.
//   NCOL      number of weighted columns (pp0..pp14)
//   PP_W      bit width of each column bundle, indexed by column weight
//   CNT_W     width of a per-column popcount (max 45)
//   PPG_BIAS  Baugh-Wooley correction constant, added once per beat
//   popcnt9   9-bit population count
//   ppg_sum_t signed 19-bit reduced sum
package ppg_pkg;

    localparam int unsigned NCOL  = 15;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned SUM_W = 19;

    localparam int unsigned PP_W [0:14] = '{18, 9, 27, 18, 36, 27, 45, 36, 36, 36, 36, 18, 18, 9, 9};

    localparam logic [SUM_W-1:0] PPG_BIAS = 19'h4E800;

    typedef logic signed [SUM_W-1:0] ppg_sum_t;

    function automatic logic [3:0] popcnt9(input logic [8:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/ppg_col_popcount.sv
// ppg_col_popcount: counts the set bits of one column bundle made of NGRP
// 9-bit groups (one group per multiplier lane set).
//   bits  in   9*NGRP  column bits
//   cnt   out  CNT_W   number of ones in bits
module ppg_col_popcount
    import ppg_pkg::*;
#(
    parameter int unsigned NGRP = 1
) (
    input  logic [9*NGRP-1:0] bits,
    output logic [CNT_W-1:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int unsigned g = 0; g < NGRP; g++) begin
            cnt = cnt + CNT_W'(popcnt9(bits[g*9 +: 9]));
        end
    end

endmodule

// File: rtl/ppg_column_reducer.sv
// ppg_column_reducer: reduces the 15 weighted PPG column bundles of one beat
// to a signed dot product through a 3-stage valid/ready pipeline
// (S1 column popcount, S2 weighted sum + bias, S3 output register).
//   clk, reset            rising-edge clock, async active-high reset
//   in_valid/in_ready     input handshake; in_first marks a new accumulation
//   pp0..pp14             column bits, column k has weight 2^k
//   out_valid/out_ready   output handshake
//   out_data              signed result, OUT_W bits
// Optional feature macro: PPG_REDUCER_ACC_EN
//   defined   -> S3 accumulates beats, restarting when in_first was set
//   undefined -> out_data is the sign-extended per-beat sum, in_first ignored
module ppg_column_reducer
    import ppg_pkg::*;
#(
    parameter int unsigned      OUT_W = 32,
    parameter logic [SUM_W-1:0] BIAS  = PPG_BIAS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic [8:0]       pp14,
    input  logic [8:0]       pp13,
    input  logic [17:0]      pp12,
    input  logic [17:0]      pp11,
    input  logic [35:0]      pp10,
    input  logic [35:0]      pp9,
    input  logic [35:0]      pp8,
    input  logic [35:0]      pp7,
    input  logic [44:0]      pp6,
    input  logic [26:0]      pp5,
    input  logic [35:0]      pp4,
    input  logic [17:0]      pp3,
    input  logic [26:0]      pp2,
    input  logic [8:0]       pp1,
    input  logic [17:0]      pp0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
);

    logic [CNT_W-1:0] col_cnt [NCOL];
    logic [CNT_W-1:0] cnt_d   [NCOL];
    logic [CNT_W-1:0] cnt_q   [NCOL];

    logic s1_load, s2_load, s3_load;
    logic s1_valid_d, s1_valid_q;
    logic s2_valid_d, s2_valid_q;
    logic s3_valid_d, s3_valid_q;

    logic [SUM_W-1:0] sum_acc;
    ppg_sum_t         sum_d, sum_q;
    logic [OUT_W-1:0] sum_ext;
    logic [OUT_W-1:0] out_d, out_q;

`ifdef PPG_REDUCER_ACC_EN
    logic s1_first_d, s1_first_q;
    logic s2_first_d, s2_first_q;
`else
    logic unused_in_first;
    assign unused_in_first = in_first;
`endif

    ppg_col_popcount #(.NGRP(PP_W[0]  / 9)) u_pc0  (.bits(pp0),  .cnt(col_cnt[0]));
    ppg_col_popcount #(.NGRP(PP_W[1]  / 9)) u_pc1  (.bits(pp1),  .cnt(col_cnt[1]));
    ppg_col_popcount #(.NGRP(PP_W[2]  / 9)) u_pc2  (.bits(pp2),  .cnt(col_cnt[2]));
    ppg_col_popcount #(.NGRP(PP_W[3]  / 9)) u_pc3  (.bits(pp3),  .cnt(col_cnt[3]));
    ppg_col_popcount #(.NGRP(PP_W[4]  / 9)) u_pc4  (.bits(pp4),  .cnt(col_cnt[4]));
    ppg_col_popcount #(.NGRP(PP_W[5]  / 9)) u_pc5  (.bits(pp5),  .cnt(col_cnt[5]));
    ppg_col_popcount #(.NGRP(PP_W[6]  / 9)) u_pc6  (.bits(pp6),  .cnt(col_cnt[6]));
    ppg_col_popcount #(.NGRP(PP_W[7]  / 9)) u_pc7  (.bits(pp7),  .cnt(col_cnt[7]));
    ppg_col_popcount #(.NGRP(PP_W[8]  / 9)) u_pc8  (.bits(pp8),  .cnt(col_cnt[8]));
    ppg_col_popcount #(.NGRP(PP_W[9]  / 9)) u_pc9  (.bits(pp9),  .cnt(col_cnt[9]));
    ppg_col_popcount #(.NGRP(PP_W[10] / 9)) u_pc10 (.bits(pp10), .cnt(col_cnt[10]));
    ppg_col_popcount #(.NGRP(PP_W[11] / 9)) u_pc11 (.bits(pp11), .cnt(col_cnt[11]));
    ppg_col_popcount #(.NGRP(PP_W[12] / 9)) u_pc12 (.bits(pp12), .cnt(col_cnt[12]));
    ppg_col_popcount #(.NGRP(PP_W[13] / 9)) u_pc13 (.bits(pp13), .cnt(col_cnt[13]));
    ppg_col_popcount #(.NGRP(PP_W[14] / 9)) u_pc14 (.bits(pp14), .cnt(col_cnt[14]));

    always_comb begin
        // A stage loads when empty or when its successor loads, so bubbles
        // collapse and a full pipe still accepts while draining.
        s3_load = !s3_valid_q || out_ready;
        s2_load = !s2_valid_q || s3_load;
        s1_load = !s1_valid_q || s2_load;
        in_ready = s1_load;

        s1_valid_d = s1_load ? in_valid   : s1_valid_q;
        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s3_valid_d = s3_load ? s2_valid_q : s3_valid_q;

        for (int unsigned k = 0; k < NCOL; k++) begin
            cnt_d[k] = (s1_load && in_valid) ? col_cnt[k] : cnt_q[k];
        end

        // Wraps mod 2^19 by construction of the accumulator width.
        sum_acc = BIAS;
        for (int unsigned k = 0; k < NCOL; k++) begin
            sum_acc = sum_acc + (SUM_W'(cnt_q[k]) << k);
        end
        sum_d = (s2_load && s1_valid_q) ? ppg_sum_t'(sum_acc) : sum_q;

        sum_ext = OUT_W'(sum_q);

`ifdef PPG_REDUCER_ACC_EN
        s1_first_d = (s1_load && in_valid)   ? in_first   : s1_first_q;
        s2_first_d = (s2_load && s1_valid_q) ? s1_first_q : s2_first_q;
        out_d = out_q;
        if (s3_load && s2_valid_q) begin
            out_d = s2_first_q ? sum_ext : out_q + sum_ext;
        end
`else
        out_d = (s3_load && s2_valid_q) ? sum_ext : out_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            for (int unsigned k = 0; k < NCOL; k++) begin
                cnt_q[k] <= '0;
            end
            sum_q <= '0;
            out_q <= '0;
`ifdef PPG_REDUCER_ACC_EN
            s1_first_q <= 1'b0;
            s2_first_q <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            for (int unsigned k = 0; k < NCOL; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            sum_q <= sum_d;
            out_q <= out_d;
`ifdef PPG_REDUCER_ACC_EN
            s1_first_q <= s1_first_d;
            s2_first_q <= s2_first_d;
`endif
        end
    end

    assign out_valid = s3_valid_q;
    assign out_data  = out_q;

endmodule
